// File: rtl/matx_prod_v2.sv
`default_nettype none
// ============================================================================
//  Module   : matx_prod_v2
//  Purpose  : Column-serial NxN matrix-vector multiplier, b = A*x or
//             b = b + A*x. N MACs work in parallel. One column of A and one
//             element of x are consumed per cycle, so a product takes N cycles.
//             Signed or unsigned operands are supported, and an overflow flag
//             is raised when any row wraps.
//  Ports    : clk       - clock, rising edge
//             nrst      - synchronous active-low reset
//             start     - operation request, sampled only in IDLE
//             acc_mode  - sampled with start; 1 adds A*x onto the held b
//             A_flat    - row-major matrix, A[0][0] in the MSBs
//             x_col     - vector, x[0] in the MSBs
//             b_col     - result vector, b[0] in the MSBs, held between runs
//             busy      - high while the MACs are running (N cycles)
//             done      - one-cycle pulse when b_col has just been updated
//             ovf       - at least one row of the last result wrapped
//  Revision : 1.0  initial release
// ============================================================================
module matx_prod_v2 #(
  parameter int N      = 4,
  parameter int DW     = 4,
  parameter int OW     = 2*DW + $clog2(N),
  parameter int SIGNED = 0
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                start,
  input  logic                acc_mode,
  input  logic [N*N*DW-1:0]   A_flat,
  input  logic [N*DW-1:0]     x_col,
  output logic [N*OW-1:0]     b_col,
  output logic                busy,
  output logic                done,
  output logic                ovf
);

  // One guard bit above the output width lets the flag detect wrap-around.
  localparam int AW = OW + 1;
  localparam int KW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [DW-1:0]     a_q   [N][N];
  logic [DW-1:0]     a_d   [N][N];
  logic [DW-1:0]     x_q   [N];
  logic [DW-1:0]     x_d   [N];
  logic [AW-1:0]     acc_q [N];
  logic [AW-1:0]     acc_d [N];
  logic [OW-1:0]     b_q   [N];
  logic [OW-1:0]     b_d   [N];
  logic              ovf_q, ovf_d;
  logic              ovf_any;

  // Full-precision product, extended to accumulator width.
  function automatic logic [AW-1:0] mul_ext(input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    logic signed [2*DW-1:0] ps;
    logic        [2*DW-1:0] pu;
    ps = $signed({{DW{a[DW-1]}}, a}) * $signed({{DW{b[DW-1]}}, b});
    pu = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
    if (SIGNED != 0) mul_ext = {{(AW-2*DW){ps[2*DW-1]}}, ps};
    else             mul_ext = {{(AW-2*DW){1'b0}}, pu};
  endfunction

  // Held result re-read as the starting accumulator value in accumulate mode.
  function automatic logic [AW-1:0] ext_b(input logic [OW-1:0] b);
    if (SIGNED != 0) ext_b = {b[OW-1], b};
    else             ext_b = {1'b0, b};
  endfunction

  // A row is out of range when the guard bit disagrees with the result's
  // top bit (signed) or is set at all (unsigned).
  function automatic logic row_ovf(input logic [AW-1:0] acc);
    if (SIGNED != 0) row_ovf = acc[AW-1] ^ acc[AW-2];
    else             row_ovf = acc[AW-1];
  endfunction

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    x_d     = x_q;
    acc_d   = acc_q;
    b_d     = b_q;
    ovf_d   = ovf_q;
    ovf_any = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
              a_d[i][j] = A_flat[(N*N-1-(i*N+j))*DW +: DW];
            end
            x_d[i]   = x_col[(N-1-i)*DW +: DW];
            acc_d[i] = acc_mode ? ext_b(b_q[i]) : '0;
          end
          k_d     = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        for (int i = 0; i < N; i++) begin
          acc_d[i] = acc_q[i] + mul_ext(a_q[i][k_q], x_q[k_q]);
        end
        k_d = k_q + KW'(1);
        if (k_q == KW'(N-1)) begin
          // Last column: publish the just-completed sums, not the stale ones.
          for (int i = 0; i < N; i++) begin
            b_d[i]  = acc_d[i][OW-1:0];
            ovf_any = ovf_any | row_ovf(acc_d[i]);
          end
          ovf_d   = ovf_any;
          k_d     = '0;
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= IDLE;
      k_q     <= '0;
      a_q     <= '{default: '{default: '0}};
      x_q     <= '{default: '0};
      acc_q   <= '{default: '0};
      b_q     <= '{default: '0};
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      x_q     <= x_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      ovf_q   <= ovf_d;
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_bout
    assign b_col[(N-1-gi)*OW +: OW] = b_q[gi];
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign ovf  = ovf_q;

endmodule
`default_nettype wire
